// File: rtl/turbo_pkg.sv
// turbo_pkg -- shared definitions for the turbo encoder transmit slice.
//
// Holds the encoder FSM state type, the interleaver table, the soft-symbol
// constants, the frame/beat geometry and the trellis step counts used by
// turbo_encoder_tx and rsc_enc.
package turbo_pkg;

  // Encoder sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } tenc_state_t;

  // Trellis geometry: 5 data steps followed by 2 termination steps
  localparam int N_STEPS      = 7;
  localparam int N_DATA_STEPS = 5;

  // Frame geometry: 7 steps x 3 symbols x 4 bits, shipped as 4 beats of 21
  // bits plus one trailing all-zero beat
  localparam int FRAME_W = 84;
  localparam int BEAT_W  = 21;
  localparam int N_BEATS = 5;

  // Soft symbols: bit 0 -> +7, bit 1 -> -7
  localparam logic [3:0] SYM_POS = 4'b0111;
  localparam logic [3:0] SYM_NEG = 4'b1001;

  // Interleaver PI = {3,0,4,1,2}; entry t lives at bits [3t+2:3t]
  localparam logic [14:0] PI_TABLE = {3'd2, 3'd1, 3'd4, 3'd0, 3'd3};

  // Returns PI[t]; termination steps fall back to index 0 because their
  // RSC2 input is taken from the feedback path, not the info word
  function automatic logic [2:0] pi_index(input logic [2:0] t);
    case (t)
      3'd0:    pi_index = PI_TABLE[2:0];
      3'd1:    pi_index = PI_TABLE[5:3];
      3'd2:    pi_index = PI_TABLE[8:6];
      3'd3:    pi_index = PI_TABLE[11:9];
      3'd4:    pi_index = PI_TABLE[14:12];
      default: pi_index = 3'd0;
    endcase
  endfunction

  // Maps a hard bit onto its soft symbol
  function automatic logic [3:0] map_sym(input logic b);
    map_sym = b ? SYM_NEG : SYM_POS;
  endfunction

endpackage

// File: rtl/turbo_encoder_tx_rsc.sv
// rsc_enc -- one recursive systematic convolutional encoder, memory 2.
//
// The caller chooses the step input (info bit or termination bit), so this
// block only holds the trellis state and evaluates one step per enabled
// cycle: a = in ^ s1 ^ s2, parity = a ^ s2, next state = (a, s1).
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset, clears the state
//   clear    synchronous state clear at the start of a frame
//   enable   advance the trellis by one step
//   in_bit   step input
//   fb_bit   s1 ^ s2, the input that drives the state toward zero
//   parity   parity bit of the current step
module rsc_enc (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic in_bit,
  output logic fb_bit,
  output logic parity
);

  logic s1_q;
  logic s2_q;
  logic a_bit;

  // Combinational trellis step from the current state
  always_comb begin
    fb_bit = s1_q ^ s2_q;
    a_bit  = in_bit ^ s1_q ^ s2_q;
    parity = a_bit ^ s2_q;
  end

  // State shift register: new a enters s1, old s1 moves to s2
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else if (enable) begin
      s1_q <= a_bit;
      s2_q <= s1_q;
    end
  end

endmodule

// File: rtl/turbo_encoder_tx.sv
// turbo_encoder_tx -- rate-1/3 turbo encoder feeding a frame-based decoder.
//
// A 5-bit info word is accepted in IDLE, encoded over 7 trellis steps by two
// RSC encoders (RSC2 sees the interleaved word), assembled into an 84-bit
// soft-symbol frame, and shipped as 5 beats with start_o high. The encoder
// then holds in WAIT until the decoder reports done_i.
//
// Parameters:
//   N_INFO  info bits per frame (only 5 is supported)
//   SYM_W   soft-symbol width (only 4 is supported)
//
// Ports:
//   clk_p_i     rising-edge clock
//   reset_n_i   synchronous active-low reset
//   valid_i     info word offered
//   data_i      info bits, u[t] = data_i[t]
//   ready_o     encoder can accept a word (IDLE, out of reset)
//   start_o     frame-beat strobe toward the decoder
//   data_o      frame beat toward the decoder
//   done_i      decoder finished, releases the next frame
//   err_mask_i  (only with TENC_ERR_INJ_EN) bit t negates the systematic
//               symbol of step t; captured together with data_i
//
// Configuration macro: TENC_ERR_INJ_EN enables the error-injection mask.
module turbo_encoder_tx
  import turbo_pkg::*;
#(
  parameter int N_INFO = 5,
  parameter int SYM_W  = 4
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              valid_i,
  input  logic [N_INFO-1:0] data_i,
  output logic              ready_o,
  output logic              start_o,
  output logic [BEAT_W-1:0] data_o,
  input  logic              done_i
`ifdef TENC_ERR_INJ_EN
  ,input logic [N_STEPS-1:0] err_mask_i
`endif
);

  localparam int STEP_BITS = 3 * SYM_W;

  tenc_state_t state_q;
  tenc_state_t state_d;

  logic [2:0]          step_q;
  logic [2:0]          step_d;
  logic [2:0]          beat_q;
  logic [2:0]          beat_d;
  logic [N_INFO-1:0]   info_q;
  logic [FRAME_W-1:0]  frame_q;
  logic                start_q;
  logic                start_d;
  logic [BEAT_W-1:0]   data_q;
  logic [BEAT_W-1:0]   data_d;

  logic                accept;
  logic                enc_en;
  logic                rsc_clear;

  logic [7:0]          info_ext;
  logic                term_step;
  logic                u_bit;
  logic                v_bit;
  logic                in1;
  logic                in2;
  logic                fb1;
  logic                fb2;
  logic                par1;
  logic                par2;
  logic                sys_bit;
  logic [STEP_BITS-1:0] step_slice;

`ifdef TENC_ERR_INJ_EN
  logic [N_STEPS-1:0]  mask_q;
`endif

  // Ready only in IDLE and never while reset is being applied
  assign ready_o = (state_q == ST_IDLE) && reset_n_i;
  assign start_o = start_q;
  assign data_o  = data_q;

  // Next-state and beat selection. Beats are registered, so the frame
  // appears one cycle after SEND begins: an accept at edge N puts beat 0 on
  // the wire after edge N+8. The last beat is still on the wire during the
  // first WAIT cycle, so done_i is only honoured once start_o has dropped.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    beat_d    = beat_q;
    accept    = 1'b0;
    enc_en    = 1'b0;
    rsc_clear = 1'b0;
    start_d   = 1'b0;
    data_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && ready_o) begin
          accept    = 1'b1;
          rsc_clear = 1'b1;
          step_d    = 3'd0;
          state_d   = ST_ENC;
        end
      end
      ST_ENC: begin
        enc_en = 1'b1;
        if (step_q == 3'(N_STEPS - 1)) begin
          beat_d  = 3'd0;
          state_d = ST_SEND;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_SEND: begin
        start_d = 1'b1;
        case (beat_q)
          3'd0:    data_d = frame_q[0*BEAT_W +: BEAT_W];
          3'd1:    data_d = frame_q[1*BEAT_W +: BEAT_W];
          3'd2:    data_d = frame_q[2*BEAT_W +: BEAT_W];
          3'd3:    data_d = frame_q[3*BEAT_W +: BEAT_W];
          default: data_d = '0;
        endcase
        if (beat_q == 3'(N_BEATS - 1)) begin
          state_d = ST_WAIT;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      ST_WAIT: begin
        if (done_i && !start_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk_p_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      beat_q  <= 3'd0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      beat_q  <= beat_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  // Step inputs: data steps feed u[t] and u[PI[t]]; the two tail steps feed
  // each encoder its own feedback so both trellises end in state zero
  always_comb begin
    info_ext              = '0;
    info_ext[N_INFO-1:0]  = info_q;
    term_step             = (step_q >= 3'(N_DATA_STEPS));
    u_bit                 = info_ext[step_q];
    v_bit                 = info_ext[pi_index(step_q)];
    in1                   = term_step ? fb1 : u_bit;
    in2                   = term_step ? fb2 : v_bit;
`ifdef TENC_ERR_INJ_EN
    sys_bit               = in1 ^ mask_q[step_q];
`else
    sys_bit               = in1;
`endif
    step_slice            = {map_sym(par2), map_sym(par1), map_sym(sys_bit)};
  end

  // Info word capture and frame assembly, one 12-bit slice per ENC step
  always_ff @(posedge clk_p_i) begin
    if (!reset_n_i) begin
      info_q  <= '0;
      frame_q <= '0;
`ifdef TENC_ERR_INJ_EN
      mask_q  <= '0;
`endif
    end else begin
      if (accept) begin
        info_q <= data_i;
`ifdef TENC_ERR_INJ_EN
        mask_q <= err_mask_i;
`endif
      end
      if (enc_en) begin
        frame_q[STEP_BITS*int'(step_q) +: STEP_BITS] <= step_slice;
      end
    end
  end

  rsc_enc u_rsc1 (
    .clk     (clk_p_i),
    .reset_n (reset_n_i),
    .clear   (rsc_clear),
    .enable  (enc_en),
    .in_bit  (in1),
    .fb_bit  (fb1),
    .parity  (par1)
  );

  rsc_enc u_rsc2 (
    .clk     (clk_p_i),
    .reset_n (reset_n_i),
    .clear   (rsc_clear),
    .enable  (enc_en),
    .in_bit  (in2),
    .fb_bit  (fb2),
    .parity  (par2)
  );

endmodule

// File: tb/tb_turbo_encoder_tx.sv
// tb_turbo_encoder_tx -- directed bench for turbo_encoder_tx.
//
// Frames for a small table of info words are hand-computed and compared
// beat by beat; hand-written sequences cover held valid_i, reset in the
// middle of SEND, early done_i and (with TENC_ERR_INJ_EN) error injection.
module tb_turbo_encoder_tx;

  logic        clk;
  logic        reset_n;
  logic        valid;
  logic [4:0]  data_in;
  logic        ready;
  logic        start;
  logic [20:0] data_out;
  logic        done;
`ifdef TENC_ERR_INJ_EN
  logic [6:0]  err_mask;
`endif

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [4:0]  data;
    logic [83:0] frame;
  } vec_t;

  vec_t vecs[4];

  turbo_encoder_tx dut (
    .clk_p_i   (clk),
    .reset_n_i (reset_n),
    .valid_i   (valid),
    .data_i    (data_in),
    .ready_o   (ready),
    .start_o   (start),
    .data_o    (data_out),
    .done_i    (done)
`ifdef TENC_ERR_INJ_EN
    ,.err_mask_i (err_mask)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if anything hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and report
  task automatic checkOutput(input string name, input logic [83:0] actual,
                             input logic [83:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Run one full frame from IDLE back to IDLE, checking latency and beats.
  // Called at a negedge with the DUT idle.
  task automatic applyStimulus(input logic [4:0] data, input logic [83:0] frame,
                               input string name);
    logic [83:0] beat_exp;
    checkOutput({name, " ready idle"}, {83'd0, ready}, 84'd1);
    valid   = 1'b1;
    data_in = data;
    @(negedge clk);
    valid = 1'b0;
    checkOutput({name, " ready enc"}, {83'd0, ready}, 84'd0);
    repeat (7) @(negedge clk);
    checkOutput({name, " start before latency"}, {83'd0, start}, 84'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      beat_exp = (k < 4) ? {63'd0, frame[21*k +: 21]} : 84'd0;
      checkOutput($sformatf("%s start beat%0d", name, k), {83'd0, start}, 84'd1);
      checkOutput($sformatf("%s data beat%0d", name, k), {63'd0, data_out}, beat_exp);
    end
    @(negedge clk);
    checkOutput({name, " start wait"}, {83'd0, start}, 84'd0);
    checkOutput({name, " data wait"}, {63'd0, data_out}, 84'd0);
    repeat (2) @(negedge clk);
    checkOutput({name, " ready wait"}, {83'd0, ready}, 84'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checkOutput({name, " ready after done"}, {83'd0, ready}, 84'd1);
  endtask

  initial begin
    int          cnt;
    logic        seen;
    logic [83:0] f;

    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    valid   = 1'b0;
    data_in = 5'd0;
    done    = 1'b0;
`ifdef TENC_ERR_INJ_EN
    err_mask = 7'd0;
`endif

    vecs[0] = '{"zeros", 5'b00000, 84'h777777777777777777777};
    vecs[1] = '{"u0",    5'b00001, 84'h999797797977997997799};
    vecs[2] = '{"ones",  5'b11111, 84'h777999779999999779999};
    vecs[3] = '{"u1u2",  5'b00110, 84'h799997797977779799777};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset start", {83'd0, start}, 84'd0);
    checkOutput("reset data", {63'd0, data_out}, 84'd0);
    checkOutput("reset ready", {83'd0, ready}, 84'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset ready", {83'd0, ready}, 84'd1);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].data, vecs[i].frame, vecs[i].name);
    end

    // Reset during beat 2 abandons the frame
    f       = vecs[0].frame;
    valid   = 1'b1;
    data_in = 5'b00000;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("rst beat2 data", {63'd0, data_out}, {63'd0, f[42 +: 21]});
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst start", {83'd0, start}, 84'd0);
    checkOutput("rst data", {63'd0, data_out}, 84'd0);
    checkOutput("rst ready", {83'd0, ready}, 84'd0);
    reset_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (start) cnt++;
    end
    checkOutput("rst no beats", 84'(cnt), 84'd0);
    applyStimulus(vecs[1].data, vecs[1].frame, "after-rst");

    // valid held high: exactly one frame per done pulse
    f       = vecs[1].frame;
    valid   = 1'b1;
    data_in = 5'b00001;
    cnt     = 0;
    seen    = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (start) begin
        if (!seen) checkOutput("held first beat", {63'd0, data_out}, {63'd0, f[20:0]});
        seen = 1'b1;
        cnt++;
      end
    end
    checkOutput("held beats frame1", 84'(cnt), 84'd5);
    checkOutput("held ready wait", {83'd0, ready}, 84'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (start) begin
        if (!seen) checkOutput("held second first beat", {63'd0, data_out}, {63'd0, f[20:0]});
        seen = 1'b1;
        cnt++;
      end
    end
    checkOutput("held beats frame2", 84'(cnt), 84'd5);
    valid = 1'b0;
    done  = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checkOutput("held back to idle", {83'd0, ready}, 84'd1);

    // done during ENC/SEND is ignored
    f       = vecs[3].frame;
    valid   = 1'b1;
    data_in = vecs[3].data;
    @(negedge clk);
    valid = 1'b0;
    done  = 1'b1;
    repeat (7) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("early-done beat%0d", k), {63'd0, data_out},
                  {63'd0, f[21*k +: 21]});
    end
    done = 1'b0;
    @(negedge clk);
    checkOutput("early-done beat4 start", {83'd0, start}, 84'd1);
    repeat (3) @(negedge clk);
    checkOutput("early-done still waiting", {83'd0, ready}, 84'd0);
    checkOutput("early-done start low", {83'd0, start}, 84'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checkOutput("early-done released", {83'd0, ready}, 84'd1);

`ifdef TENC_ERR_INJ_EN
    // Systematic symbol of step 0 negated
    err_mask = 7'b0000001;
    applyStimulus(5'b00000, 84'h777777777777777777779, "errinj");
    err_mask = 7'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
